// File: rtl/mtr_arb.sv
// Motor-command arbiter: passes PID duties through, or runs a timed stop/reverse/pivot
// bump recovery. Optional output slew limiting is enabled by defining MTR_ARB_SLEW_EN.
module mtr_arb #(
  parameter int unsigned FAST_SIM    = 0,
  parameter int unsigned STOP_TICKS  = 4,
  parameter int unsigned BACK_TICKS  = 32,
  parameter int unsigned PIVOT_TICKS = 16,
  parameter int unsigned BACK_DUTY   = 512,
  parameter int unsigned PIVOT_DUTY  = 384,
  parameter int unsigned SLEW_STEP   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               go,
  input  logic               BMP_n,
  input  logic signed [11:0] pid_lft,
  input  logic signed [11:0] pid_rght,
  output logic signed [11:0] lft_duty,
  output logic signed [11:0] rght_duty,
  output logic               recov_busy,
  output logic               buzz_req,
  output logic               pivot_dir
);

  typedef enum logic [1:0] {StPass, StStop, StBack, StPivot} state_e;

  localparam logic [15:0]        PRESC_TC   = (FAST_SIM != 0) ? 16'd15 : 16'hffff;
  localparam logic [7:0]         STOP_LAST  = 8'(STOP_TICKS - 1);
  localparam logic [7:0]         BACK_LAST  = 8'(BACK_TICKS - 1);
  localparam logic [7:0]         PIVOT_LAST = 8'(PIVOT_TICKS - 1);
  localparam logic signed [11:0] BACK_MAG   = 12'(BACK_DUTY);
  localparam logic signed [11:0] PIVOT_MAG  = 12'(PIVOT_DUTY);

  state_e             state_q, state_d;
  logic [15:0]        presc_q, presc_d;
  logic [7:0]         tick_cnt_q, tick_cnt_d;
  logic               pivot_dir_q, pivot_dir_d;
  logic signed [11:0] lft_q, lft_d, rght_q, rght_d;
  logic signed [11:0] tgt_l, tgt_r;
  logic               tick, expire;
  logic [7:0]         last_cnt;

  // State sequencing and tick timing
  always_comb begin
    state_d     = state_q;
    pivot_dir_d = pivot_dir_q;
    tick        = (presc_q == PRESC_TC);
    case (state_q)
      StStop:  last_cnt = STOP_LAST;
      StBack:  last_cnt = BACK_LAST;
      StPivot: last_cnt = PIVOT_LAST;
      default: last_cnt = 8'd0;
    endcase
    expire = tick && (tick_cnt_q == last_cnt);

    if (!go) begin
      state_d = StPass;
    end else begin
      case (state_q)
        StPass:  if (!BMP_n) state_d = StStop;
        StStop:  if (expire) state_d = StBack;
        StBack:  if (expire) state_d = StPivot;
        StPivot: begin
          // A fresh bump restarts recovery without consuming this pivot's direction
          if (!BMP_n) begin
            state_d = StStop;
          end else if (expire) begin
            state_d     = StPass;
            pivot_dir_d = ~pivot_dir_q;
          end
        end
        default: state_d = StPass;
      endcase
    end

    if ((state_d != state_q) || (state_q == StPass)) begin
      presc_d    = '0;
      tick_cnt_d = '0;
    end else begin
      presc_d    = tick ? 16'd0 : presc_q + 16'd1;
      tick_cnt_d = tick ? tick_cnt_q + 8'd1 : tick_cnt_q;
    end
  end

  always_comb begin
    tgt_l = '0;
    tgt_r = '0;
    if (go) begin
      case (state_q)
        StPass: begin
          tgt_l = pid_lft;
          tgt_r = pid_rght;
        end
        StBack: begin
          tgt_l = -BACK_MAG;
          tgt_r = -BACK_MAG;
        end
        StPivot: begin
          tgt_l = pivot_dir_q ? -PIVOT_MAG : PIVOT_MAG;
          tgt_r = pivot_dir_q ? PIVOT_MAG : -PIVOT_MAG;
        end
        default: begin
          tgt_l = '0;
          tgt_r = '0;
        end
      endcase
    end
  end

`ifdef MTR_ARB_SLEW_EN
  logic [7:0] slew_cnt_q;
  logic       strobe;

  function automatic logic signed [11:0] slew_to(input logic signed [11:0] cur,
                                                 input logic signed [11:0] tgt);
    logic signed [12:0] step, cur_x, diff, res;
    step  = 13'(SLEW_STEP);
    cur_x = {cur[11], cur};
    diff  = {tgt[11], tgt} - cur_x;
    if (diff > step) begin
      res = cur_x + step;
    end else if (diff < -step) begin
      res = cur_x - step;
    end else begin
      res = {tgt[11], tgt};
    end
    return res[11:0];
  endfunction

  always_comb begin
    strobe = (FAST_SIM != 0) || (slew_cnt_q == 8'hff);
    if (!go) begin
      lft_d  = '0;
      rght_d = '0;
    end else if (strobe) begin
      lft_d  = slew_to(lft_q, tgt_l);
      rght_d = slew_to(rght_q, tgt_r);
    end else begin
      lft_d  = lft_q;
      rght_d = rght_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) slew_cnt_q <= '0;
    else        slew_cnt_q <= slew_cnt_q + 8'd1;
  end
`else
  logic unused_slew;
  assign unused_slew = ^SLEW_STEP;

  always_comb begin
    lft_d  = tgt_l;
    rght_d = tgt_r;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StPass;
      presc_q     <= '0;
      tick_cnt_q  <= '0;
      pivot_dir_q <= 1'b0;
      lft_q       <= '0;
      rght_q      <= '0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      tick_cnt_q  <= tick_cnt_d;
      pivot_dir_q <= pivot_dir_d;
      lft_q       <= lft_d;
      rght_q      <= rght_d;
    end
  end

  assign lft_duty   = lft_q;
  assign rght_duty  = rght_q;
  assign pivot_dir  = pivot_dir_q;
  assign recov_busy = (state_q != StPass);
  assign buzz_req   = (state_q == StStop) || (state_q == StBack);

endmodule

// File: tb/tb_mtr_arb.sv
// Directed bench for mtr_arb with FAST_SIM=1 (16 clk per tick) and default durations.
module tb_mtr_arb;

  logic               clk, rst_n, go, BMP_n;
  logic signed [11:0] pid_lft, pid_rght, lft_duty, rght_duty;
  logic               recov_busy, buzz_req, pivot_dir;
  int                 checks = 0;
  int                 errors = 0;

  mtr_arb #(.FAST_SIM(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .go         (go),
    .BMP_n      (BMP_n),
    .pid_lft    (pid_lft),
    .pid_rght   (pid_rght),
    .lft_duty   (lft_duty),
    .rght_duty  (rght_duty),
    .recov_busy (recov_busy),
    .buzz_req   (buzz_req),
    .pivot_dir  (pivot_dir)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, leaving time 1 unit past the last edge
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_duty(input string tag, input int l, input int r);
    chk({tag, "_lft"}, lft_duty, l);
    chk({tag, "_rght"}, rght_duty, r);
  endtask

  initial begin
    rst_n    = 1'b0;
    go       = 1'b0;
    BMP_n    = 1'b1;
    pid_lft  = '0;
    pid_rght = '0;
    #12;
    chk_duty("rst", 0, 0);
    chk("rst_busy", recov_busy, 0);
    chk("rst_buzz", buzz_req, 0);
    chk("rst_dir", pivot_dir, 0);
    rst_n = 1'b1;
    step(1);

    // Pass-through, one clk latency
    go = 1'b1; pid_lft = 12'sd300; pid_rght = -12'sd250;
    step(1);
    chk_duty("pass", 300, -250);
    chk("pass_busy", recov_busy, 0);
`ifndef MTR_ARB_SLEW_EN
    pid_lft = -12'sd2048;
    step(1);
    chk("pass_min", lft_duty, -2048);
    pid_lft = 12'sd300;
    step(1);
`endif

    // go=0 beats a bump in PASS
    go = 1'b0; BMP_n = 1'b0;
    step(1);
    chk("nogo_busy", recov_busy, 0);
    chk_duty("nogo", 0, 0);
    go = 1'b1; BMP_n = 1'b1;
    step(4);

    // Full recovery sequence; bump sampled at edge k
    BMP_n = 1'b0;
    step(1);
    BMP_n = 1'b1;
    chk("k_busy", recov_busy, 1);
    chk("k_buzz", buzz_req, 1);
    chk("k_lft", lft_duty, 300);
    step(1);
    chk_duty("stop_first", 0, 0);
    step(63);
    chk_duty("stop_last", 0, 0);
    chk("back_buzz", buzz_req, 1);
    step(1);
    chk_duty("back_first", -512, -512);
    step(511);
    chk_duty("back_last", -512, -512);
    chk("pivot_buzz", buzz_req, 0);
    chk("pivot_busy", recov_busy, 1);
    step(1);
    chk_duty("pivot_r", 384, -384);
    chk("pivot_r_dir", pivot_dir, 0);
    step(255);
    chk("pivot_r_last", lft_duty, 384);
    chk("done_busy", recov_busy, 0);
    chk("done_dir", pivot_dir, 1);
    step(1);
    chk_duty("done_pass", 300, -250);

    // Second recovery pivots left; bump 100 clk into PIVOT restarts STOP
    BMP_n = 1'b0;
    step(1);
    BMP_n = 1'b1;
    step(576);
    chk("m_back_last", lft_duty, -512);
    step(1);
    chk_duty("pivot_l", -384, 384);
    chk("pivot_l_dir", pivot_dir, 1);
    step(99);
    BMP_n = 1'b0;
    step(1);
    BMP_n = 1'b1;
    chk("rebump_buzz", buzz_req, 1);
    chk("rebump_dir", pivot_dir, 1);
    step(1);
    chk_duty("restop_first", 0, 0);
    step(63);
    chk_duty("restop_last", 0, 0);
    step(1);
    chk_duty("reback", -512, -512);

    // Abort mid-BACK
    step(100);
    go = 1'b0;
    step(1);
    chk_duty("abort", 0, 0);
    chk("abort_busy", recov_busy, 0);
    chk("abort_buzz", buzz_req, 0);
    chk("abort_dir", pivot_dir, 1);
    go = 1'b1; pid_lft = 12'sd100; pid_rght = -12'sd100;
    step(1);
`ifndef MTR_ARB_SLEW_EN
    chk_duty("resume", 100, -100);
`endif
    chk("resume_busy", recov_busy, 0);

    // Asynchronous reset mid-BACK
    step(3);
    BMP_n = 1'b0;
    step(1);
    BMP_n = 1'b1;
    step(165);
`ifndef MTR_ARB_SLEW_EN
    chk_duty("prerst_back", -512, -512);
`endif
    chk("prerst_buzz", buzz_req, 1);
    #1 rst_n = 1'b0;
    #1;
    chk_duty("arst", 0, 0);
    chk("arst_busy", recov_busy, 0);
    chk("arst_buzz", buzz_req, 0);
    chk("arst_dir", pivot_dir, 0);
    #1 rst_n = 1'b1;
    step(1);

`ifdef MTR_ARB_SLEW_EN
    pid_lft = 12'sd0; pid_rght = 12'sd0;
    step(2);
    chk("slew_zero", lft_duty, 0);
    pid_lft = 12'sd100;
    for (int i = 1; i <= 6; i++) begin
      step(1);
      chk("slew_ramp", lft_duty, 16 * i);
    end
    step(1);
    chk("slew_snap", lft_duty, 100);
`else
    pid_lft = 12'sd100; pid_rght = 12'sd0;
    step(1);
    chk_duty("noslew_step", 100, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
